// File: rtl/trap_if.sv
// Bus between the execute stage and the trap unit: the trapping instruction
// context flows in, pipeline control, redirect and CSR read-back flow out.
interface trap_if #(
    parameter int XLEN = 32
);
    logic            trapReq;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;

    modport master (
        output trapReq, instruction, pc, rs1_data,
        input  stall, flush, redirect_valid, redirect_pc, rd_we, rd_addr, rd_data
    );

    modport slave (
        input  trapReq, instruction, pc, rs1_data,
        output stall, flush, redirect_valid, redirect_pc, rd_we, rd_addr, rd_data
    );
endinterface

// File: rtl/trap_unit.sv
// Machine-mode trap unit: executes ECALL/EBREAK/MRET and CSRRW/S/C[I] for
// SYSTEM-opcode instructions sitting in execute, owns mtvec/mscratch/mepc/mcause,
// and stalls, flushes and redirects the pipeline as needed.
module trap_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
    input logic   clk,
    input logic   rst,
    trap_if.slave bus
);
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        CSR_WB,
        SAVE,
        REDIRECT
    } state_t;

    state_t state_q, state_d;

    // Context of the instruction accepted in IDLE (opcode bits are not needed)
    logic [31:7]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_q;
    logic [3:0]      cause_q, cause_d;
    logic            mret_q, mret_d;

    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;

    // Incoming decode fields
    logic [2:0]  in_f3;
    logic [11:0] in_f12;
    assign in_f3  = bus.instruction[14:12];
    assign in_f12 = bus.instruction[31:20];

    // Latched fields used during CSR writeback
    logic [2:0]      wb_f3;
    logic [11:0]     wb_addr;
    logic [4:0]      wb_zimm;
    logic [XLEN-1:0] csr_old, csr_src, csr_new;
    logic            csr_we;
    assign wb_f3   = instr_q[14:12];
    assign wb_addr = instr_q[31:20];
    assign wb_zimm = instr_q[19:15];

    function automatic logic csr_supported(input logic [11:0] addr);
        return (addr == CSR_MTVEC) || (addr == CSR_MSCRATCH) ||
               (addr == CSR_MEPC)  || (addr == CSR_MCAUSE);
    endfunction

    // CSR read mux and read-modify-write value for the latched CSR instruction
    always_comb begin
        csr_old = '0;
        case (wb_addr)
            CSR_MTVEC:    csr_old = mtvec_q;
            CSR_MSCRATCH: csr_old = mscratch_q;
            CSR_MEPC:     csr_old = mepc_q;
            CSR_MCAUSE:   csr_old = mcause_q;
            default:      csr_old = '0;
        endcase
        // funct3[2] selects the 5-bit zero-extended immediate over rs1
        csr_src = wb_f3[2] ? {{(XLEN-5){1'b0}}, wb_zimm} : rs1_q;
        case (wb_f3[1:0])
            2'b01:   csr_new = csr_src;
            2'b10:   csr_new = csr_old | csr_src;
            default: csr_new = csr_old & ~csr_src;
        endcase
        // Set/clear with a zero rs1 field is a pure read
        csr_we = (state_q == CSR_WB) && ((wb_f3[1:0] == 2'b01) || (wb_zimm != 5'd0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the trapping instruction's context when it is accepted
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.trapReq) begin
            instr_q <= bus.instruction[31:7];
            pc_q    <= bus.pc;
            rs1_q   <= bus.rs1_data;
            cause_q <= cause_d;
            mret_q  <= mret_d;
        end
    end

    // CSR file: software writes commit at the end of CSR_WB, trap state at the end of SAVE
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (csr_we) begin
            case (wb_addr)
                CSR_MTVEC:    mtvec_q    <= {csr_new[XLEN-1:2], 2'b00};
                CSR_MSCRATCH: mscratch_q <= csr_new;
                CSR_MEPC:     mepc_q     <= {csr_new[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   mcause_q   <= csr_new;
                default:      ;
            endcase
        end else if (state_q == SAVE) begin
            mepc_q   <= pc_q;
            mcause_q <= {{(XLEN-4){1'b0}}, cause_q};
        end
    end

    // Next-state decode and pipeline-control outputs
    always_comb begin
        state_d            = state_q;
        cause_d            = CAUSE_ILLEGAL;
        mret_d             = 1'b0;
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.rd_we          = 1'b0;
        bus.rd_addr        = '0;
        bus.rd_data        = '0;
        case (state_q)
            IDLE: begin
                if (bus.trapReq) begin
                    bus.stall = 1'b1;
                    if (in_f3 != 3'b000) begin
                        // funct3 = 100 is not a CSR op
                        if (in_f3 != 3'b100 && csr_supported(in_f12)) begin
                            state_d = CSR_WB;
                        end else begin
                            state_d = SAVE;
                        end
                    end else begin
                        case (in_f12)
                            12'h000: begin
                                state_d = SAVE;
                                cause_d = CAUSE_ECALL;
                            end
                            12'h001: begin
                                state_d = SAVE;
                                cause_d = CAUSE_BREAK;
                            end
                            12'h302: begin
                                state_d = REDIRECT;
                                mret_d  = 1'b1;
                            end
                            default: state_d = SAVE;
                        endcase
                    end
                end
            end
            CSR_WB: begin
                bus.rd_addr = instr_q[11:7];
                bus.rd_we   = (instr_q[11:7] != 5'd0);
                bus.rd_data = csr_old;
                state_d     = IDLE;
            end
            SAVE: begin
                bus.stall = 1'b1;
                state_d   = REDIRECT;
            end
            REDIRECT: begin
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = mret_q ? mepc_q : mtvec_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_unit.sv
// Bench for trap_unit: directed scenarios followed by random SYSTEM
// instructions, checked cycle by cycle against an architectural CSR model.
module tb_trap_unit;
    logic clk;
    logic rst;

    trap_if #(.XLEN(32)) bus ();

    trap_unit #(.XLEN(32), .RESET_MTVEC(32'h0000_0100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Architectural CSR state
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit st, input bit fl, input bit rv,
                              input logic [31:0] rpc, input bit we, input logic [4:0] ra,
                              input logic [31:0] rdd);
        chk({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, st});
        chk({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, fl});
        chk({tag, ".redirect_valid"}, {31'd0, bus.redirect_valid}, {31'd0, rv});
        chk({tag, ".redirect_pc"}, bus.redirect_pc, rpc);
        chk({tag, ".rd_we"}, {31'd0, bus.rd_we}, {31'd0, we});
        chk({tag, ".rd_addr"}, {27'd0, bus.rd_addr}, {27'd0, ra});
        chk({tag, ".rd_data"}, bus.rd_data, rdd);
    endtask

    function automatic void model_reset();
        m_mtvec    = 32'h0000_0100;
        m_mscratch = 32'h0;
        m_mepc     = 32'h0;
        m_mcause   = 32'h0;
    endfunction

    function automatic bit supported(input logic [11:0] a);
        return a == 12'h305 || a == 12'h340 || a == 12'h341 || a == 12'h342;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h305: m_mtvec    = v & 32'hFFFF_FFFC;
            12'h340: m_mscratch = v;
            12'h341: m_mepc     = v & 32'hFFFF_FFFC;
            12'h342: m_mcause   = v;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [11:0] f12, input logic [4:0] rs1f,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f12, rs1f, f3, rd, 7'b1110011};
    endfunction

    task automatic drive_junk();
        bus.trapReq     = 1'($urandom_range(0, 1));
        bus.instruction = $urandom;
        bus.pc          = $urandom;
        bus.rs1_data    = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.trapReq = 1'b0;
        @(negedge clk);
        #1;
        model_reset();
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // Issue one instruction and follow it to its closing IDLE cycle
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] pcv,
                             input logic [31:0] rs1d, input bit rst_mid,
                             output logic [31:0] rd_obs, output logic [31:0] rpc_obs);
        logic [2:0]  f3;
        logic [11:0] f12;
        logic [4:0]  rd, rs1f;
        logic [31:0] old, src, nv;
        int          kind;      // 0 csr, 1 trap, 2 mret
        logic [31:0] cause;
        f3   = ins[14:12];
        f12  = ins[31:20];
        rd   = ins[11:7];
        rs1f = ins[19:15];
        cause = 32'd2;
        rd_obs  = 32'h0;
        rpc_obs = 32'h0;
        if (f3 != 3'd0) kind = (f3 != 3'd4 && supported(f12)) ? 0 : 1;
        else if (f12 == 12'h000) begin kind = 1; cause = 32'd11; end
        else if (f12 == 12'h001) begin kind = 1; cause = 32'd3; end
        else if (f12 == 12'h302) kind = 2;
        else kind = 1;

        @(negedge clk);
        bus.trapReq     = 1'b1;
        bus.instruction = ins;
        bus.pc          = pcv;
        bus.rs1_data    = rs1d;
        #1;
        check_outs("accept", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive_junk();
        #1;
        if (kind == 0) begin
            old = model_read(f12);
            check_outs("csr_wb", 0, 0, 0, 0, rd != 5'd0, rd, old);
            rd_obs = bus.rd_data;
            src = f3[2] ? {27'd0, rs1f} : rs1d;
            if (f3[1:0] == 2'b01) nv = src;
            else if (f3[1:0] == 2'b10) nv = old | src;
            else nv = old & ~src;
            if (f3[1:0] == 2'b01 || rs1f != 5'd0) model_write(f12, nv);
        end else if (kind == 2) begin
            check_outs("mret", 0, 1, 1, m_mepc, 0, 0, 0);
            rpc_obs = bus.redirect_pc;
        end else begin
            check_outs("save", 1, 0, 0, 0, 0, 0, 0);
            if (rst_mid) begin
                rst         = 1'b1;
                bus.trapReq = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                model_reset();
                check_outs("rst_in_save", 0, 0, 0, 0, 0, 0, 0);
                return;
            end
            @(negedge clk);
            drive_junk();
            m_mepc   = pcv;
            m_mcause = cause;
            #1;
            check_outs("trap_redirect", 0, 1, 1, m_mtvec, 0, 0, 0);
            rpc_obs = bus.redirect_pc;
        end
        @(negedge clk);
        bus.trapReq = 1'b0;
        #1;
        check_outs("idle", 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read_csr(input logic [11:0] a, output logic [31:0] v);
        logic [31:0] dummy;
        run_instr(enc(a, 5'd0, 3'b010, 5'd1), 32'h0000_1000, 32'h0, 1'b0, v, dummy);
    endtask

    // Hard bound on run time
    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdo, rpco, v, pcv, ins;
        logic [2:0]  f3tab [6];
        logic [11:0] atab [5];
        f3tab = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        atab  = '{12'h305, 12'h340, 12'h341, 12'h342, 12'h300};

        rst = 1'b0;
        bus.trapReq = 1'b0;
        bus.instruction = 32'h0;
        bus.pc = 32'h0;
        bus.rs1_data = 32'h0;
        model_reset();
        do_reset();

        // CSRRW x5, mtvec, x1 with x1 = 0x2003
        run_instr(enc(12'h305, 5'd1, 3'b001, 5'd5), 32'h20, 32'h2003, 1'b0, rdo, rpco);
        chk("t1_old_mtvec", rdo, 32'h100);
        read_csr(12'h305, v);
        chk("t1_mtvec", v, 32'h2000);

        // ECALL at 0x40
        run_instr(enc(12'h000, 5'd0, 3'b000, 5'd0), 32'h40, 32'h0, 1'b0, rdo, rpco);
        chk("t2_target", rpco, 32'h2000);
        read_csr(12'h341, v);
        chk("t2_mepc", v, 32'h40);
        read_csr(12'h342, v);
        chk("t2_mcause", v, 32'd11);

        // MRET
        run_instr(enc(12'h302, 5'd0, 3'b000, 5'd0), 32'h2000, 32'h0, 1'b0, rdo, rpco);
        chk("t3_target", rpco, 32'h40);
        read_csr(12'h342, v);
        chk("t3_mcause", v, 32'd11);

        // mscratch read-only set, then clear-immediate
        run_instr(enc(12'h340, 5'd2, 3'b001, 5'd0), 32'h50, 32'hA5, 1'b0, rdo, rpco);
        run_instr(enc(12'h340, 5'd0, 3'b010, 5'd0), 32'h54, 32'hFFFF_FFFF, 1'b0, rdo, rpco);
        read_csr(12'h340, v);
        chk("t4_mscratch_kept", v, 32'hA5);
        run_instr(enc(12'h340, 5'd5, 3'b111, 5'd3), 32'h58, 32'h0, 1'b0, rdo, rpco);
        chk("t4_rcio_old", rdo, 32'hA5);
        read_csr(12'h340, v);
        chk("t4_mscratch_cleared", v, 32'hA0);

        // Illegal CSR address, then EBREAK
        run_instr(enc(12'h300, 5'd1, 3'b001, 5'd4), 32'h60, 32'h1234, 1'b0, rdo, rpco);
        read_csr(12'h342, v);
        chk("t5_illegal_cause", v, 32'd2);
        run_instr(enc(12'h001, 5'd0, 3'b000, 5'd0), 32'h64, 32'h0, 1'b0, rdo, rpco);
        read_csr(12'h342, v);
        chk("t5_ebreak_cause", v, 32'd3);

        // Reset during SAVE drops the redirect and restores CSRs
        run_instr(enc(12'h000, 5'd0, 3'b000, 5'd0), 32'h80, 32'h0, 1'b1, rdo, rpco);
        read_csr(12'h341, v);
        chk("t6_mepc", v, 32'h0);
        read_csr(12'h305, v);
        chk("t6_mtvec", v, 32'h100);

        // Random SYSTEM instructions
        for (int i = 0; i < 300; i++) begin
            pcv = $urandom;
            pcv[1:0] = 2'b00;
            case ($urandom_range(0, 7))
                0, 1, 2: begin
                    logic [11:0] a;
                    logic [4:0]  r1;
                    a  = ($urandom_range(0, 5) == 5) ? 12'($urandom) : atab[$urandom_range(0, 4)];
                    r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                    ins = enc(a, r1, f3tab[$urandom_range(0, 5)], 5'($urandom));
                end
                3: ins = enc(12'h000, 5'd0, 3'b000, 5'd0);
                4: ins = enc(12'h001, 5'd0, 3'b000, 5'd0);
                5: ins = enc(12'h302, 5'd0, 3'b000, 5'd0);
                6: ins = enc(atab[$urandom_range(0, 4)], 5'($urandom), 3'b100, 5'($urandom));
                default: ins = enc(12'($urandom), 5'($urandom), 3'b000, 5'($urandom));
            endcase
            run_instr(ins, pcv, $urandom, ($urandom_range(0, 29) == 0), rdo, rpco);
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
